sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised FIFO buffer built around a dual-port storage array, replacing raw address-driven memory access with self-managed pointers, occupancy tracking and status flags. It sits between a producer and a consumer in the same clock domain, accepting writes and reads through enable strobes. Width, depth and threshold levels are parameters; sticky error reporting is a compile-time option.

## Interface
- N, 8, data width in bits
- DEEP, 3, address width; storage depth is 2**DEEP words
- AF_LEVEL, 2**DEEP-1, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL

- clk_in  input  1  single clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- data_in  input  N  write data
- w_en  input  1  write request
- r_en  input  1  read request
- data_o  output  N  registered read data
- full  output  1  count == 2**DEEP
- empty  output  1  count == 0
- almost_full  output  1  count >= AF_LEVEL
- almost_empty  output  1  count <= AE_LEVEL
- count  output  DEEP+1  current occupancy, 0..2**DEEP
- overflow  output  1  sticky, present only with FIFO_ERR_FLAGS_EN
- underflow  output  1  sticky, present only with FIFO_ERR_FLAGS_EN

## Operation
- Write pointer wr_ptr and read pointer rd_ptr, each DEEP+1 bits; low DEEP bits address storage, MSB is wrap bit; both increment modulo 2**(DEEP+1).
- count = wr_ptr - rd_ptr, modulo 2**(DEEP+1); full when MSBs differ and low bits equal; empty when pointers equal.
- Read accepted (rd_acc) = r_en && !empty.
- Write accepted (wr_acc) = w_en && (!full || rd_acc): when full, a simultaneous accepted read frees a slot and the write is taken.
- Empty with simultaneous w_en and r_en: write accepted, read rejected (no bypass).
- wr_acc: storage[wr_ptr low bits] <= data_in; wr_ptr increments.
- rd_acc: data_o <= storage[rd_ptr low bits]; rd_ptr increments. No rd_acc: data_o holds previous value.
- Both accepted: count unchanged.
- Status outputs decode combinationally from registered pointers only; no combinational path from w_en/r_en/data_in to any output.
- Reset mid-operation: pointers return to 0 immediately; storage contents are not cleared and are unreachable.

## Timing
- Reset values: data_o 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0 (AF_LEVEL >= 1 required), overflow 0, underflow 0.
- Write latency: word written at edge k is readable (rd_acc possible) at edge k+1; empty deasserts after edge k.
- Read latency: rd_acc at edge k drives data_o after edge k, valid throughout cycle k+1.
- Flags and count update after the same edge that moves the pointers.
- Full throughput: one write and one read per cycle sustained.

## Configuration
- FIFO_ERR_FLAGS_EN defined: overflow sets on any edge with w_en && !wr_acc; underflow sets on any edge with r_en && empty; both stay 1 until rst. FIFO state is unaffected by rejected requests either way.
- FIFO_ERR_FLAGS_EN undefined: overflow/underflow ports and logic absent; rejected requests are silently dropped.

## Structure
- Shared package sync_fifo_pkg: pointer-width constant function (DEEP+1), default threshold constants, flag-decode helper for full/empty comparison.
- One sub-module sync_fifo_ram: 2**DEEP x N array, one write port, one registered read port, both on clk_in; read register reset to 0 by rst. Pointer/flag logic stays in sync_fifo.

## Test plan
- Reset, then idle 3 cycles -> count 0, empty 1, full 0, almost_empty 1, data_o 8'h00.
- Write 8'h01..8'h08 on consecutive cycles (N=8, DEEP=3) -> full 1 after 8th edge, almost_full 1 after 7th, count 8; 9th write with r_en=0 rejected, overflow 1 (macro on).
- From full, read 8 times -> data_o 8'h01..8'h08 in order, one per cycle after each edge; empty 1 after last; extra read -> data_o holds 8'h08, underflow 1.
- From full, w_en=r_en=1 with data_in 8'hAA -> read returns oldest word, write accepted, count stays 8, full stays 1.
- From empty, w_en=r_en=1 with data_in 8'h55 -> write accepted, read rejected, count 1, data_o unchanged.
- Write 5, read 5, repeated 4 times -> pointers wrap past 2**DEEP, data order preserved, empty after each round; assert rst mid-burst -> count 0, empty 1 immediately, no clock needed.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// ============================================================================
// Module : sync_fifo_pkg
// Brief  : Shared constants, pointer-width helper and full/empty flag decode
//          for sync_fifo.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_fifo_pkg;

    localparam int DEF_N        = 8;
    localparam int DEF_DEEP     = 3;
    localparam int DEF_AE_LEVEL = 1;

    typedef struct packed {
        logic full;
        logic empty;
    } fifo_flags_t;

    // One extra wrap bit beyond the storage address.
    function automatic int ptr_width(input int deep);
        return deep + 1;
    endfunction

    // Pointers are zero-extended to 32 bits by the caller.
    function automatic fifo_flags_t decode_flags(input logic [31:0] wr,
                                                 input logic [31:0] rd,
                                                 input int          deep);
        fifo_flags_t f;
        logic [31:0] low_mask;
        low_mask = (32'd1 << deep) - 32'd1;
        f.empty  = (wr == rd);
        f.full   = (((wr ^ rd) & low_mask) == 32'd0) &&
                   (((wr >> deep) & 32'd1) != ((rd >> deep) & 32'd1));
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_ram.sv
// ============================================================================
// Module : sync_fifo_ram
// Brief  : 2**DEEP x N storage with one write port and one registered read port.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int DEEP = DEF_DEEP
) (
    input  logic            clk_in,
    input  logic            rst,
    input  logic            we_i,
    input  logic [DEEP-1:0] waddr_i,
    input  logic [N-1:0]    wdata_i,
    input  logic            re_i,
    input  logic [DEEP-1:0] raddr_i,
    output logic [N-1:0]    rdata_o
);

    logic [N-1:0] mem_q [2**DEEP];
    logic [N-1:0] rdata_q;

    // Storage is deliberately left unreset.
    always_ff @(posedge clk_in) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module : sync_fifo
// Brief  : Single-clock FIFO with occupancy count and threshold flags.
//          Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int DEEP     = DEF_DEEP,
    parameter int AF_LEVEL = 2**DEEP - 1,
    parameter int AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [N-1:0]      data_in,
    input  logic              w_en,
    input  logic              r_en,
    output logic [N-1:0]      data_o,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
`ifdef FIFO_ERR_FLAGS_EN
    output logic              overflow,
    output logic              underflow,
`endif
    output logic [DEEP:0]     count
);

    localparam int            PW   = ptr_width(DEEP);
    localparam logic [PW-1:0] C_AF = PW'(AF_LEVEL);
    localparam logic [PW-1:0] C_AE = PW'(AE_LEVEL);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          rd_acc, wr_acc;
    fifo_flags_t   flags;

    assign flags = decode_flags(32'(wr_ptr_q), 32'(rd_ptr_q), DEEP);

    assign full         = flags.full;
    assign empty        = flags.empty;
    assign count        = wr_ptr_q - rd_ptr_q;
    assign almost_full  = (count >= C_AF);
    assign almost_empty = (count <= C_AE);

    // A read from a full FIFO frees the slot the same-cycle write lands in.
    assign rd_acc = r_en && !flags.empty;
    assign wr_acc = w_en && (!flags.full || rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (w_en && !wr_acc) begin
                overflow_q <= 1'b1;
            end
            if (r_en && flags.empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

    sync_fifo_ram #(
        .N    (N),
        .DEEP (DEEP)
    ) u_ram (
        .clk_in  (clk_in),
        .rst     (rst),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[DEEP-1:0]),
        .wdata_i (data_in),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q[DEEP-1:0]),
        .rdata_o (data_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo.sv
// ============================================================================
// Module : tb_sync_fifo
// Brief  : Directed self-checking bench for sync_fifo (N=8, DEEP=3).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo;

    logic       clk_in = 1'b0;
    logic       rst    = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       w_en   = 1'b0;
    logic       r_en   = 1'b0;
    logic [7:0] data_o;
    logic       full, empty, almost_full, almost_empty;
    logic [3:0] count;
`ifdef FIFO_ERR_FLAGS_EN
    logic       overflow, underflow;
`endif

    int checks = 0;
    int errors = 0;

    sync_fifo #(
        .N        (8),
        .DEEP     (3),
        .AF_LEVEL (7),
        .AE_LEVEL (1)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .data_in      (data_in),
        .w_en         (w_en),
        .r_en         (r_en),
        .data_o       (data_o),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`ifdef FIFO_ERR_FLAGS_EN
        .overflow     (overflow),
        .underflow    (underflow),
`endif
        .count        (count)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then sit 1ns past it for checks and new inputs.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        w_en = 1'b0;
        r_en = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        repeat (3) step();

        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ae", 32'(almost_empty), 32'd1);
        check("rst_af", 32'(almost_full), 32'd0);
        check("rst_data", 32'(data_o), 32'h00);
`ifdef FIFO_ERR_FLAGS_EN
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_unf", 32'(underflow), 32'd0);
`endif

        // Fill with 01..08.
        for (int i = 1; i <= 8; i++) begin
            data_in = 8'(i);
            w_en    = 1'b1;
            step();
            check("fill_count", 32'(count), 32'(i));
            check("fill_empty", 32'(empty), 32'd0);
            check("fill_ae", 32'(almost_empty), (i <= 1) ? 32'd1 : 32'd0);
            check("fill_af", 32'(almost_full), (i >= 7) ? 32'd1 : 32'd0);
            check("fill_full", 32'(full), (i == 8) ? 32'd1 : 32'd0);
        end

        // Ninth write is rejected.
        data_in = 8'h99;
        step();
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_full", 32'(full), 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
        check("ovf_flag", 32'(overflow), 32'd1);
`endif
        idle();

        // Drain in order.
        for (int i = 1; i <= 8; i++) begin
            r_en = 1'b1;
            step();
            check("drain_data", 32'(data_o), 32'(i));
            check("drain_count", 32'(count), 32'(8 - i));
            check("drain_full", 32'(full), 32'd0);
            check("drain_empty", 32'(empty), (i == 8) ? 32'd1 : 32'd0);
        end

        // Extra read: data holds, nothing moves.
        step();
        check("unf_data", 32'(data_o), 32'h08);
        check("unf_count", 32'(count), 32'd0);
        check("unf_empty", 32'(empty), 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
        check("unf_flag", 32'(underflow), 32'd1);
`endif
        idle();

        // Refill with 11..18.
        for (int i = 0; i < 8; i++) begin
            data_in = 8'h11 + 8'(i);
            w_en    = 1'b1;
            step();
        end
        check("refill_full", 32'(full), 32'd1);

        // Simultaneous read/write while full.
        data_in = 8'hAA;
        w_en    = 1'b1;
        r_en    = 1'b1;
        step();
        check("fullrw_data", 32'(data_o), 32'h11);
        check("fullrw_count", 32'(count), 32'd8);
        check("fullrw_full", 32'(full), 32'd1);
        idle();

        // Remaining contents: 12..18 then AA.
        for (int i = 0; i < 8; i++) begin
            r_en = 1'b1;
            step();
            check("fullrw_drain", 32'(data_o), (i == 7) ? 32'hAA : 32'(8'h12 + 8'(i)));
        end
        idle();
        step();
        check("fullrw_empty", 32'(empty), 32'd1);

        // Simultaneous read/write while empty: no bypass.
        data_in = 8'h55;
        w_en    = 1'b1;
        r_en    = 1'b1;
        step();
        check("emptyrw_count", 32'(count), 32'd1);
        check("emptyrw_data", 32'(data_o), 32'hAA);
        check("emptyrw_empty", 32'(empty), 32'd0);
        w_en = 1'b0;
        step();
        check("emptyrw_read", 32'(data_o), 32'h55);
        check("emptyrw_count0", 32'(count), 32'd0);
        idle();

        // Wrap the pointers: four rounds of five writes and five reads.
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 5; j++) begin
                data_in = 8'h20 + 8'(r * 8 + j);
                w_en    = 1'b1;
                step();
            end
            w_en = 1'b0;
            check("wrap_count5", 32'(count), 32'd5);
            for (int j = 0; j < 5; j++) begin
                r_en = 1'b1;
                step();
                check("wrap_data", 32'(data_o), 32'(8'h20 + 8'(r * 8 + j)));
            end
            r_en = 1'b0;
            check("wrap_empty", 32'(empty), 32'd1);
        end

        // Asynchronous reset in the middle of a burst.
        for (int j = 0; j < 3; j++) begin
            data_in = 8'hC0 + 8'(j);
            w_en    = 1'b1;
            step();
        end
        check("burst_count", 32'(count), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("async_count", 32'(count), 32'd0);
        check("async_empty", 32'(empty), 32'd1);
        check("async_data", 32'(data_o), 32'h00);
`ifdef FIFO_ERR_FLAGS_EN
        check("async_ovf", 32'(overflow), 32'd0);
`endif
        idle();
        step();
        rst = 1'b0;
        step();
        check("post_rst_empty", 32'(empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
